// File: rtl/core_pkg.sv
// Shared definitions for the multicycle RV32I core:
// opcodes, sequencer states, opcode classes and datapath select codes.
package core_pkg;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;

  typedef enum logic [2:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_ALU,
    C_ALUI,
    C_LUI,
    C_AUIPC,
    C_JAL,
    C_JALR,
    C_BR,
    C_LD,
    C_ST,
    C_FENCE,
    C_ILL
  } cls_t;

  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;

  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] B_FOUR = 2'd2;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_FN  = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MDR = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_REL = 2'd1;
  localparam logic [1:0] PC_JR  = 2'd2;

  localparam logic [1:0] TC_NONE = 2'd0;
  localparam logic [1:0] TC_ILL  = 2'd1;
  localparam logic [1:0] TC_TMO  = 2'd2;

  function automatic cls_t classify(input logic [6:0] op);
    cls_t c;
    c = C_ILL;
    unique case (1'b1)
      op == OP:       c = C_ALU;
      op == OP_IMM:   c = C_ALUI;
      op == LUI:      c = C_LUI;
      op == AUIPC:    c = C_AUIPC;
      op == JAL:      c = C_JAL;
      op == JALR:     c = C_JALR;
      op == BRANCH:   c = C_BR;
      op == LOAD:     c = C_LD;
      op == STORE:    c = C_ST;
      op == MISC_MEM: c = C_FENCE;
      default:        c = C_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; hit flags the cycle in which
// one more unanswered wait would reach the timeout limit.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TMO_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int LAST_I =
    (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [TMO_W-1:0] LAST = TMO_W'(LAST_I);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A zero limit disables the timeout altogether.
  assign hit = (MEM_TIMEOUT != 0) && en && (cnt == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Main sequencer of the multicycle RV32I core:
// FETCH/DECODE/EXEC/MEM/WB with datapath enables and selects.
module multicycle_control
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TMO_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_we,
  output logic       imm_we,
  output logic       mdr_we,
  output logic [1:0] alu_a_sel,
  output logic [1:0] alu_b_sel,
  output logic [1:0] alu_op,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       instret,
  output logic       trap,
  output logic [1:0] trap_cause
);

  state_t     st_q, st_d;
  cls_t       cls_q, dec_cls;
  logic [1:0] cause_q;
  logic       waiting, tmo_clr, tmo_en, tmo_hit;

  // funct3 is decoded by the ALU, not by the sequencer.
  logic unused_funct3;
  assign unused_funct3 = ^funct3;

  assign dec_cls = classify(opcode);
  assign waiting = (st_q == S_FETCH) || (st_q == S_MEM);
  assign tmo_clr = !waiting || mem_ready;
  assign tmo_en  = waiting && !mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TMO_W      (TMO_W)
  ) u_tmo (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tmo_clr),
    .en   (tmo_en),
    .hit  (tmo_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= S_RST;
      cls_q   <= C_ILL;
      cause_q <= TC_NONE;
    end else begin
      st_q <= st_d;
      if (st_q == S_DECODE) begin
        cls_q <= dec_cls;
      end
      if (st_d == S_TRAP && st_q != S_TRAP) begin
        cause_q <= (st_q == S_DECODE) ? TC_ILL : TC_TMO;
      end
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      S_RST: st_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)    st_d = S_DECODE;
        else if (tmo_hit) st_d = S_TRAP;
      end
      S_DECODE: begin
        st_d = (dec_cls == C_ILL) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        unique case (1'b1)
          cls_q == C_LD,
          cls_q == C_ST:    st_d = S_MEM;
          cls_q == C_BR,
          cls_q == C_FENCE: st_d = S_FETCH;
          default:          st_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          st_d = (cls_q == C_ST) ? S_FETCH : S_WB;
        end else if (tmo_hit) begin
          st_d = S_TRAP;
        end
      end
      S_WB:    st_d = S_FETCH;
      S_TRAP:  st_d = S_TRAP;
      default: st_d = S_RST;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_we      = 1'b0;
    imm_we     = 1'b0;
    mdr_we     = 1'b0;
    alu_a_sel  = A_RS1;
    alu_b_sel  = B_RS2;
    alu_op     = OP_ADD;
    rf_we      = 1'b0;
    wb_sel     = WB_ALU;
    pc_we      = 1'b0;
    pc_src     = PC_SEQ;
    instret    = 1'b0;
    trap       = 1'b0;
    trap_cause = TC_NONE;
    unique case (st_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      S_DECODE: imm_we = 1'b1;
      S_EXEC: begin
        unique case (1'b1)
          cls_q == C_ALU: alu_op = OP_FN;
          cls_q == C_ALUI: begin
            alu_b_sel = B_IMM;
            alu_op    = OP_FN;
          end
          cls_q == C_AUIPC: begin
            alu_a_sel = A_PC;
            alu_b_sel = B_IMM;
          end
          cls_q == C_LD,
          cls_q == C_ST: alu_b_sel = B_IMM;
          cls_q == C_BR: begin
            alu_op  = OP_SUB;
            pc_we   = 1'b1;
            pc_src  = br_taken ? PC_REL : PC_SEQ;
            instret = 1'b1;
          end
          cls_q == C_FENCE: begin
            pc_we   = 1'b1;
            instret = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (cls_q == C_ST);
        if (mem_ready) begin
          mdr_we  = (cls_q == C_LD);
          pc_we   = (cls_q == C_ST);
          instret = (cls_q == C_ST);
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        instret = 1'b1;
        unique case (1'b1)
          cls_q == C_LD:  wb_sel = WB_MDR;
          cls_q == C_JAL: begin
            wb_sel = WB_PC4;
            pc_src = PC_REL;
          end
          cls_q == C_JALR: begin
            wb_sel = WB_PC4;
            pc_src = PC_JR;
          end
          cls_q == C_LUI: wb_sel = WB_IMM;
          default:        wb_sel = WB_ALU;
        endcase
      end
      S_TRAP: begin
        trap       = 1'b1;
        trap_cause = cause_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised instruction-level checker for multicycle_control:
// expands each instruction into its expected per-cycle outputs.
module tb_multicycle_control;

  localparam int T = 4;

  localparam logic [6:0] O_OP    = 7'b0110011;
  localparam logic [6:0] O_OPIMM = 7'b0010011;
  localparam logic [6:0] O_LUI   = 7'b0110111;
  localparam logic [6:0] O_AUIPC = 7'b0010111;
  localparam logic [6:0] O_JAL   = 7'b1101111;
  localparam logic [6:0] O_JALR  = 7'b1100111;
  localparam logic [6:0] O_BR    = 7'b1100011;
  localparam logic [6:0] O_LD    = 7'b0000011;
  localparam logic [6:0] O_ST    = 7'b0100011;
  localparam logic [6:0] O_MISC  = 7'b0001111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       br_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, addr_sel, ir_we, imm_we, mdr_we;
  logic [1:0] alu_a_sel, alu_b_sel, alu_op, wb_sel, pc_src;
  logic [1:0] trap_cause;
  logic       rf_we, pc_we, instret, trap;

  multicycle_control #(.MEM_TIMEOUT(T), .TMO_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .br_taken(br_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_we(ir_we), .imm_we(imm_we), .mdr_we(mdr_we),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
    .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_src(pc_src),
    .instret(instret), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_we, addr_sel, ir_we, imm_we, mdr_we;
    logic [1:0] alu_a, alu_b, alu_op;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       instret, trap;
    logic [1:0] cause;
  } out_t;

  typedef struct {
    logic [6:0] opc;
    logic       rdy, br, rst;
    out_t       exp;
    int         id;
  } cyc_t;

  cyc_t q[$];
  int ntest = 0, nfail = 0, nret = 0, retired = 0, cur_id = 0;
  logic [6:0] legal_ops [10] = '{O_OP, O_OPIMM, O_LUI, O_AUIPC,
    O_JAL, O_JALR, O_BR, O_LD, O_ST, O_MISC};

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] ro();
    return 7'($urandom);
  endfunction

  function automatic bit legal(input logic [6:0] o);
    foreach (legal_ops[i]) if (legal_ops[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push(input logic [6:0] o, input logic r,
                      input logic b, input logic rs, input out_t e);
    cyc_t c;
    c.opc = o; c.rdy = r; c.br = b; c.rst = rs;
    c.exp = e; c.id = cur_id;
    q.push_back(c);
  endtask

  task automatic do_reset();
    push(ro(), rb(), rb(), 1'b1, '0);
  endtask

  task automatic do_trap(input logic [1:0] cause);
    out_t e;
    e = '0; e.trap = 1'b1; e.cause = cause;
    repeat (3) push(ro(), rb(), rb(), 1'b0, e);
    do_reset();
  endtask

  // Expected cycles of one instruction; waits >= T end in a timeout trap.
  task automatic instr(input logic [6:0] o, input int wf, input int wm,
                       input logic br, input int abort);
    out_t e;
    bit ld, st;
    cur_id++;
    ld = (o == O_LD);
    st = (o == O_ST);
    for (int i = 0; i < wf && i < T; i++) begin
      e = '0; e.mem_req = 1'b1;
      push(ro(), 1'b0, rb(), 1'b0, e);
    end
    if (wf >= T) begin do_trap(2'd2); return; end
    e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1;
    push(ro(), 1'b1, rb(), 1'b0, e);
    e = '0; e.imm_we = 1'b1;
    push(o, rb(), rb(), 1'b0, e);
    if (!legal(o)) begin do_trap(2'd1); return; end
    e = '0;
    case (o)
      O_OP:    e.alu_op = 2'd2;
      O_OPIMM: begin e.alu_b = 2'd1; e.alu_op = 2'd2; end
      O_AUIPC: begin e.alu_a = 2'd1; e.alu_b = 2'd1; end
      O_LD, O_ST: e.alu_b = 2'd1;
      O_BR: begin
        e.alu_op = 2'd1; e.pc_we = 1'b1;
        e.pc_src = {1'b0, br}; e.instret = 1'b1;
      end
      O_MISC: begin e.pc_we = 1'b1; e.instret = 1'b1; end
      default: ;
    endcase
    push(o, rb(), br, 1'b0, e);
    if (o == O_BR || o == O_MISC) begin retired++; return; end
    if (ld || st) begin
      for (int i = 0; i < wm && i < T; i++) begin
        if (i == abort) begin do_reset(); return; end
        e = '0; e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = st;
        push(o, 1'b0, rb(), 1'b0, e);
      end
      if (wm >= T) begin do_trap(2'd2); return; end
      e = '0; e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = st;
      e.pc_we = st; e.instret = st; e.mdr_we = ld;
      push(o, 1'b1, rb(), 1'b0, e);
      if (st) begin retired++; return; end
    end
    e = '0; e.rf_we = 1'b1; e.pc_we = 1'b1; e.instret = 1'b1;
    e.wb_sel = ld ? 2'd1 : (o == O_JAL || o == O_JALR) ? 2'd2 :
               (o == O_LUI) ? 2'd3 : 2'd0;
    e.pc_src = (o == O_JAL) ? 2'd1 : (o == O_JALR) ? 2'd2 : 2'd0;
    push(o, rb(), rb(), 1'b0, e);
    retired++;
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    ntest++;
    if (got != want) begin
      nfail++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  function automatic out_t cur();
    out_t o;
    o.mem_req = mem_req; o.mem_we = mem_we; o.addr_sel = addr_sel;
    o.ir_we = ir_we; o.imm_we = imm_we; o.mdr_we = mdr_we;
    o.alu_a = alu_a_sel; o.alu_b = alu_b_sel; o.alu_op = alu_op;
    o.rf_we = rf_we; o.wb_sel = wb_sel; o.pc_we = pc_we;
    o.pc_src = pc_src; o.instret = instret; o.trap = trap;
    o.cause = trap_cause;
    return o;
  endfunction

  task automatic cmp(input cyc_t c, input int cyc, input string nm);
    out_t a;
    a = cur();
    ntest++;
    if (a !== c.exp) begin
      nfail++;
      $display("FAIL %s cyc%0d instr%0d got=%h want=%h",
               nm, cyc, c.id, a, c.exp);
    end
  endtask

  initial begin
    int s, wf, wm, ab;
    logic [6:0] o;
    cyc_t c;

    do_reset();
    s = q.size(); instr(O_OPIMM, 0, 0, 1'b0, -1);
    chk_int("len_addi", q.size() - s, 4);
    s = q.size(); instr(O_LD, 0, 3, 1'b0, -1);
    chk_int("len_lw_wait3", q.size() - s, 8);
    s = q.size(); instr(O_BR, 0, 0, 1'b1, -1);
    chk_int("len_beq_t", q.size() - s, 3);
    s = q.size(); instr(O_BR, 0, 0, 1'b0, -1);
    chk_int("len_beq_nt", q.size() - s, 3);
    s = q.size(); instr(O_JALR, 0, 0, 1'b0, -1);
    chk_int("len_jalr", q.size() - s, 4);
    instr(7'b1110011, 0, 0, 1'b0, -1);
    instr(O_OP, T, 0, 1'b0, -1);
    instr(O_OP, T - 1, 0, 1'b0, -1);
    instr(O_ST, 0, 3, 1'b0, 2);
    s = q.size(); instr(O_ST, 0, 0, 1'b0, -1);
    chk_int("len_sw", q.size() - s, 4);
    s = q.size(); instr(O_LD, 0, 0, 1'b0, -1);
    chk_int("len_lw", q.size() - s, 5);
    instr(O_ST, 1, T, 1'b0, -1);
    instr(O_LD, 0, T - 1, 1'b0, -1);
    instr(O_JAL, 2, 0, 1'b0, -1);
    instr(O_LUI, 0, 0, 1'b0, -1);
    instr(O_AUIPC, 1, 0, 1'b0, -1);
    instr(O_MISC, 0, 0, 1'b0, -1);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        do o = ro(); while (legal(o));
      end else begin
        o = legal_ops[$urandom_range(0, 9)];
      end
      wf = ($urandom_range(0, 29) == 0) ? T + $urandom_range(0, 2)
                                        : $urandom_range(0, 2);
      wm = ($urandom_range(0, 19) == 0) ? T + $urandom_range(0, 2)
                                        : $urandom_range(0, 3);
      ab = -1;
      if (wm > 0 && wm < T && $urandom_range(0, 29) == 0)
        ab = $urandom_range(0, wm - 1);
      instr(o, wf, wm, rb(), ab);
    end

    for (int cyc = 0; q.size() > 0; cyc++) begin
      c = q.pop_front();
      @(negedge clk);
      opcode = c.opc;
      mem_ready = c.rdy;
      br_taken = c.br;
      funct3 = 3'($urandom);
      if (c.rst) rst_n = 1'b0;
      #1;
      cmp(c, cyc, c.rst ? "in_reset" : "outputs");
      if (!c.rst && instret === 1'b1) nret++;
      if (c.rst) begin
        #1 rst_n = 1'b1;
        #1 cmp(c, cyc, "after_release");
      end
    end
    chk_int("retire_count", nret, retired);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
